// File: rtl/lsm_continuation_eval_if.sv
// -----------------------------------------------------------------------------
// lsm_continuation_eval_if
// Handshake bundle for the LSM continuation-value evaluator.
//   beta channel   : beta_valid_in / beta_ready_out / beta_in[0:2]
//   record channel : valid_in / ready_out / x_in / pay_in / cf_in
//   result channel : valid_out / ready_in / cf_out / exercise_out / last_out
// Modports:
//   slave  - the evaluator's view (consumes beta and records, produces results)
//   master - the upstream/downstream environment's view
// -----------------------------------------------------------------------------
interface lsm_continuation_eval_if #(
    parameter int WIDTH = 24
) ();
    logic                    beta_valid_in;
    logic                    beta_ready_out;
    logic signed [WIDTH-1:0] beta_in [0:2];

    logic                    valid_in;
    logic                    ready_out;
    logic signed [WIDTH-1:0] x_in;
    logic signed [WIDTH-1:0] pay_in;
    logic signed [WIDTH-1:0] cf_in;

    logic                    valid_out;
    logic                    ready_in;
    logic signed [WIDTH-1:0] cf_out;
    logic                    exercise_out;
    logic                    last_out;

    modport slave (
        input  beta_valid_in, beta_in, valid_in, x_in, pay_in, cf_in, ready_in,
        output beta_ready_out, ready_out, valid_out, cf_out, exercise_out, last_out
    );

    modport master (
        output beta_valid_in, beta_in, valid_in, x_in, pay_in, cf_in, ready_in,
        input  beta_ready_out, ready_out, valid_out, cf_out, exercise_out, last_out
    );
endinterface

// File: rtl/lsm_continuation_eval.sv
// -----------------------------------------------------------------------------
// lsm_continuation_eval
// Continuation-value evaluator for the LSM backward-induction loop. A beta
// triple is latched once per exercise date; then N_SAMPLES path records are
// streamed through a 3-stage fixed-point pipeline computing
//     C = b0 + b1*x + b2*x^2
// and each path's cash flow is replaced by its payoff when exercising is at
// least as good as continuing (and the payoff is positive).
//
// Ports:
//   clk, rst_n     - single clock, asynchronous active-low reset
//   bus (slave)    - beta / record / result handshake channels
//   ex_count_out   - (only with LSM_CONT_EVAL_STATS_EN) number of results
//                    accepted with exercise_out=1 in the current batch
//
// Optional feature macro: LSM_CONT_EVAL_STATS_EN
// -----------------------------------------------------------------------------
module lsm_continuation_eval #(
    parameter int WIDTH     = 24,
    parameter int QINT      = 8,
    parameter int QFRAC     = 16,
    parameter int N_SAMPLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lsm_continuation_eval_if.slave bus
`ifdef LSM_CONT_EVAL_STATS_EN
    ,
    output logic [$clog2(N_SAMPLES+1)-1:0] ex_count_out
`endif
);

    // Integer bits take precedence if QINT+QFRAC disagree with WIDTH.
    localparam int FRAC_BITS = (QINT + QFRAC == WIDTH) ? QFRAC : (WIDTH - QINT);
    localparam int PW        = 2 * WIDTH + 1;
    localparam int AW        = WIDTH + 1;
    localparam int CW        = $clog2(N_SAMPLES + 1);

    localparam logic signed [WIDTH-1:0] MAX_W  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic signed [PW-1:0]    MAX_P  = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0]    MIN_P  = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW-1:0]    RND_P  = {{(PW-1){1'b0}}, 1'b1} << (FRAC_BITS - 1);

    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_SAMPLES - 1);

    // Fixed-point multiply: round half up, then clamp to the WIDTH range.
    function automatic logic signed [WIDTH-1:0] fx_mul(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [PW-1:0] p;
        p = PW'(a) * PW'(b);
        p = p + RND_P;
        p = p >>> FRAC_BITS;
        if (p > MAX_P) begin
            fx_mul = MAX_W;
        end else if (p < MIN_P) begin
            fx_mul = MIN_W;
        end else begin
            fx_mul = p[WIDTH-1:0];
        end
    endfunction

    // Fixed-point add with saturation; overflow shows as differing top bits.
    function automatic logic signed [WIDTH-1:0] fx_add(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b
    );
        logic signed [AW-1:0] s;
        s = AW'(a) + AW'(b);
        if (s[AW-1] != s[AW-2]) begin
            fx_add = s[AW-1] ? MIN_W : MAX_W;
        end else begin
            fx_add = s[WIDTH-1:0];
        end
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic signed [WIDTH-1:0] beta_q [0:2];
    logic signed [WIDTH-1:0] beta_d [0:2];
    logic [CW-1:0]           in_cnt_q, in_cnt_d;
    logic [CW-1:0]           out_cnt_q, out_cnt_d;

    // Stage 1: x^2 and b1*x
    logic                    v1_q, v1_d;
    logic signed [WIDTH-1:0] x2_1_q, x2_1_d, t1_1_q, t1_1_d, pay1_q, pay1_d, cf1_q, cf1_d;
    // Stage 2: b2*x^2 and b0+b1*x
    logic                    v2_q, v2_d;
    logic signed [WIDTH-1:0] t2_2_q, t2_2_d, s_2_q, s_2_d, pay2_q, pay2_d, cf2_q, cf2_d;
    // Stage 3: continuation value
    logic                    v3_q, v3_d;
    logic signed [WIDTH-1:0] c3_q, c3_d, pay3_q, pay3_d, cf3_q, cf3_d;
    // Output register
    logic                    valid_out_q, valid_out_d;
    logic signed [WIDTH-1:0] cf_out_q, cf_out_d;
    logic                    ex_out_q, ex_out_d;
    logic                    last_out_q, last_out_d;

    logic                    en_s;
    logic                    beta_ready_out_s;
    logic                    ready_out_s;
    logic                    beta_fire_s;
    logic                    in_fire_s;
    logic                    out_fire_s;
    logic signed [WIDTH-1:0] x2_s, t1_s, t2_s, s_s, c_s;
    logic                    ex_s;

    assign en_s        = !valid_out_q || bus.ready_in;
    assign beta_fire_s = bus.beta_valid_in && beta_ready_out_s;
    assign in_fire_s   = bus.valid_in && ready_out_s;
    assign out_fire_s  = valid_out_q && bus.ready_in;

    assign x2_s = fx_mul(bus.x_in, bus.x_in);
    assign t1_s = fx_mul(beta_q[1], bus.x_in);
    assign t2_s = fx_mul(beta_q[2], x2_1_q);
    assign s_s  = fx_add(beta_q[0], t1_1_q);
    assign c_s  = fx_add(s_2_q, t2_2_q);
    assign ex_s = (pay3_q > ZERO_W) && (pay3_q >= c3_q);

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (beta_fire_s) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (in_fire_s && (in_cnt_q == LAST_IDX)) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (out_fire_s && last_out_q) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: beta only in IDLE, records only in RUN and only when the pipe moves
    always_comb begin
        beta_ready_out_s = 1'b0;
        ready_out_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                beta_ready_out_s = 1'b1;
            end
            S_RUN: begin
                ready_out_s = en_s;
            end
            S_DRAIN: begin
                ready_out_s = 1'b0;
            end
            default: begin
                beta_ready_out_s = 1'b0;
                ready_out_s      = 1'b0;
            end
        endcase
    end

    // Beta latch and batch counters
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            beta_d[i] = beta_q[i];
        end
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (beta_fire_s) begin
            for (int i = 0; i < 3; i++) begin
                beta_d[i] = bus.beta_in[i];
            end
            in_cnt_d  = CNT_ZERO;
            out_cnt_d = CNT_ZERO;
        end else begin
            if (in_fire_s) begin
                in_cnt_d = in_cnt_q + CNT_ONE;
            end else begin
                in_cnt_d = in_cnt_q;
            end
            if (out_fire_s) begin
                out_cnt_d = out_cnt_q + CNT_ONE;
            end else begin
                out_cnt_d = out_cnt_q;
            end
        end
    end

    // Beta and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                beta_q[i] <= ZERO_W;
            end
            in_cnt_q  <= CNT_ZERO;
            out_cnt_q <= CNT_ZERO;
        end else begin
            for (int i = 0; i < 3; i++) begin
                beta_q[i] <= beta_d[i];
            end
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Pipeline advance: every stage moves together when en_s, otherwise holds
    always_comb begin
        v1_d = v1_q; x2_1_d = x2_1_q; t1_1_d = t1_1_q; pay1_d = pay1_q; cf1_d = cf1_q;
        v2_d = v2_q; t2_2_d = t2_2_q; s_2_d = s_2_q; pay2_d = pay2_q; cf2_d = cf2_q;
        v3_d = v3_q; c3_d = c3_q; pay3_d = pay3_q; cf3_d = cf3_q;
        valid_out_d = valid_out_q;
        cf_out_d    = cf_out_q;
        ex_out_d    = ex_out_q;
        last_out_d  = last_out_q;
        if (en_s) begin
            v1_d   = in_fire_s;
            x2_1_d = x2_s;
            t1_1_d = t1_s;
            pay1_d = bus.pay_in;
            cf1_d  = bus.cf_in;

            v2_d   = v1_q;
            t2_2_d = t2_s;
            s_2_d  = s_s;
            pay2_d = pay1_q;
            cf2_d  = cf1_q;

            v3_d   = v2_q;
            c3_d   = c_s;
            pay3_d = pay2_q;
            cf3_d  = cf2_q;

            valid_out_d = v3_q;
            cf_out_d    = v3_q ? (ex_s ? pay3_q : cf3_q) : ZERO_W;
            ex_out_d    = v3_q && ex_s;
            // out_cnt_d is the number of results already accepted once this one is at the head
            last_out_d  = v3_q && (out_cnt_d == LAST_IDX);
        end else begin
            valid_out_d = valid_out_q;
        end
    end

    // Pipeline and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q <= 1'b0; x2_1_q <= ZERO_W; t1_1_q <= ZERO_W; pay1_q <= ZERO_W; cf1_q <= ZERO_W;
            v2_q <= 1'b0; t2_2_q <= ZERO_W; s_2_q <= ZERO_W; pay2_q <= ZERO_W; cf2_q <= ZERO_W;
            v3_q <= 1'b0; c3_q <= ZERO_W; pay3_q <= ZERO_W; cf3_q <= ZERO_W;
            valid_out_q <= 1'b0;
            cf_out_q    <= ZERO_W;
            ex_out_q    <= 1'b0;
            last_out_q  <= 1'b0;
        end else begin
            v1_q <= v1_d; x2_1_q <= x2_1_d; t1_1_q <= t1_1_d; pay1_q <= pay1_d; cf1_q <= cf1_d;
            v2_q <= v2_d; t2_2_q <= t2_2_d; s_2_q <= s_2_d; pay2_q <= pay2_d; cf2_q <= cf2_d;
            v3_q <= v3_d; c3_q <= c3_d; pay3_q <= pay3_d; cf3_q <= cf3_d;
            valid_out_q <= valid_out_d;
            cf_out_q    <= cf_out_d;
            ex_out_q    <= ex_out_d;
            last_out_q  <= last_out_d;
        end
    end

`ifdef LSM_CONT_EVAL_STATS_EN
    logic [CW-1:0] ex_cnt_q, ex_cnt_d;

    // Exercise statistics: cleared by a new beta, held after the batch ends
    always_comb begin
        ex_cnt_d = ex_cnt_q;
        if (beta_fire_s) begin
            ex_cnt_d = CNT_ZERO;
        end else if (out_fire_s && ex_out_q) begin
            ex_cnt_d = ex_cnt_q + CNT_ONE;
        end else begin
            ex_cnt_d = ex_cnt_q;
        end
    end

    // Exercise statistics register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_cnt_q <= CNT_ZERO;
        end else begin
            ex_cnt_q <= ex_cnt_d;
        end
    end

    assign ex_count_out = ex_cnt_q;
`endif

    assign bus.beta_ready_out = beta_ready_out_s;
    assign bus.ready_out      = ready_out_s;
    assign bus.valid_out      = valid_out_q;
    assign bus.cf_out         = cf_out_q;
    assign bus.exercise_out   = ex_out_q;
    assign bus.last_out       = last_out_q;

endmodule

// File: tb/tb_lsm_continuation_eval.sv
// -----------------------------------------------------------------------------
// tb_lsm_continuation_eval
// Directed bench for lsm_continuation_eval. A reference model computes the
// continuation value with plain integer arithmetic, predicts each result on
// record acceptance and a negedge monitor compares every visible result.
// -----------------------------------------------------------------------------
module tb_lsm_continuation_eval;

    localparam int W  = 24;
    localparam int QF = 16;
    localparam int N  = 16;
    localparam longint SMAX = (longint'(1) << (W - 1)) - 1;
    localparam longint SMIN = -(longint'(1) << (W - 1));

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    lsm_continuation_eval_if #(.WIDTH(W)) bus ();

`ifdef LSM_CONT_EVAL_STATS_EN
    logic [$clog2(N+1)-1:0] ex_count;
`endif

    lsm_continuation_eval #(
        .WIDTH(W), .QINT(8), .QFRAC(QF), .N_SAMPLES(N)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef LSM_CONT_EVAL_STATS_EN
        ,
        .ex_count_out (ex_count)
`endif
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        longint cf;
        bit     ex;
        bit     last;
    } exp_t;
    exp_t   sb[$];

    longint mb0, mb1, mb2;
    bit     have_beta = 1'b0;
    int     m_in_cnt  = 0;
    int     m_ex_cnt  = 0;

    // literal expectations riding with the record currently offered
    bit     lit_v  = 1'b0;
    longint lit_cf = 0;
    bit     lit_ex = 1'b0;

    bit lat_mode = 1'b0;
    int lat_acc = -1, lat_val = -1, lat_last_fire = -1, lat_fires = 0;
    bit bp_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint sat(input longint v);
        if (v > SMAX) return SMAX;
        if (v < SMIN) return SMIN;
        return v;
    endfunction

    function automatic longint fmul(input longint a, input longint b);
        return sat((a * b + (longint'(1) << (QF - 1))) >>> QF);
    endfunction

    function automatic longint fadd(input longint a, input longint b);
        return sat(a + b);
    endfunction

    function automatic longint cont(input longint b0, input longint b1, input longint b2, input longint x);
        return fadd(fadd(b0, fmul(b1, x)), fmul(b2, fmul(x, x)));
    endfunction

    // Downstream ready: random ~25% low when backpressure is enabled
    initial begin
        bus.ready_in = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.ready_in = bp_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    // Monitor / scoreboard: sampled on the falling edge
    always @(negedge clk) begin
        exp_t   e;
        longint c;
        bit     ex;
        cyc++;
        if (!rst_n) begin
            sb.delete();
            have_beta = 1'b0;
            m_in_cnt  = 0;
            m_ex_cnt  = 0;
        end else begin
`ifdef LSM_CONT_EVAL_STATS_EN
            check("ex_count", longint'(ex_count), m_ex_cnt);
`endif
            if (bus.valid_out) begin
                if (lat_mode && lat_val < 0) lat_val = cyc;
                if (sb.size() == 0) begin
                    check("unexpected_valid_out", 1, 0);
                end else begin
                    check("cf_out", longint'(bus.cf_out), sb[0].cf);
                    check("exercise_out", longint'(bus.exercise_out), longint'(sb[0].ex));
                    check("last_out", longint'(bus.last_out), longint'(sb[0].last));
                    if (bus.ready_in) begin
                        if (sb[0].ex) m_ex_cnt++;
                        if (sb[0].last) check("beta_ready_on_last_fire", longint'(bus.beta_ready_out), 0);
                        void'(sb.pop_front());
                        if (lat_mode) begin
                            lat_fires++;
                            lat_last_fire = cyc;
                        end
                    end
                end
            end
            if (bus.valid_in && bus.ready_out) begin
                check("accept_allowed", longint'(have_beta && (m_in_cnt < N)), 1);
                if (lat_mode && lat_acc < 0) lat_acc = cyc;
                c  = cont(mb0, mb1, mb2, longint'(bus.x_in));
                ex = (bus.pay_in > 0) && (longint'(bus.pay_in) >= c);
                e.cf   = ex ? longint'(bus.pay_in) : longint'(bus.cf_in);
                e.ex   = ex;
                e.last = (m_in_cnt == N - 1);
                sb.push_back(e);
                m_in_cnt++;
                if (lit_v) begin
                    check("model_vs_hand_cf", e.cf, lit_cf);
                    check("model_vs_hand_ex", longint'(e.ex), longint'(lit_ex));
                end
            end
            if (bus.beta_valid_in && bus.beta_ready_out) begin
                check("beta_accept_between_batches",
                      longint'((sb.size() == 0) && (m_in_cnt == 0 || m_in_cnt == N)), 1);
                mb0 = longint'(bus.beta_in[0]);
                mb1 = longint'(bus.beta_in[1]);
                mb2 = longint'(bus.beta_in[2]);
                have_beta = 1'b1;
                m_in_cnt  = 0;
                m_ex_cnt  = 0;
            end
        end
    end

    task automatic send_beta(input longint b0, input longint b1, input longint b2);
        bit hs = 1'b0;
        int n  = 0;
        bus.beta_in[0] = b0[W-1:0];
        bus.beta_in[1] = b1[W-1:0];
        bus.beta_in[2] = b2[W-1:0];
        bus.beta_valid_in = 1'b1;
        while (!hs && n < 400) begin
            @(negedge clk);
            hs = bus.beta_ready_out;
            @(posedge clk);
            #1;
            n++;
        end
        bus.beta_valid_in = 1'b0;
        if (!hs) check("beta_handshake_timeout", 0, 1);
    endtask

    task automatic send_rec(input longint x, input longint pay, input longint cf,
                            input bit lv, input longint lcf, input bit lex);
        bit hs = 1'b0;
        int n  = 0;
        bus.x_in   = x[W-1:0];
        bus.pay_in = pay[W-1:0];
        bus.cf_in  = cf[W-1:0];
        lit_v  = lv;
        lit_cf = lcf;
        lit_ex = lex;
        bus.valid_in = 1'b1;
        while (!hs && n < 400) begin
            @(negedge clk);
            hs = bus.ready_out;
            @(posedge clk);
            #1;
            n++;
        end
        bus.valid_in = 1'b0;
        lit_v = 1'b0;
        if (!hs) check("record_handshake_timeout", 0, 1);
    endtask

    task automatic send_fill(input int from_k);
        for (int k = from_k; k <= N; k++) begin
            send_rec(longint'(k) * 16384, longint'(k) * 9000, longint'(k) * 500, 1'b0, 0, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(bus.beta_ready_out && sb.size() == 0) && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 400) check("drain_timeout", 0, 1);
    endtask

    initial begin
        bus.beta_valid_in = 1'b0;
        bus.beta_in[0] = '0; bus.beta_in[1] = '0; bus.beta_in[2] = '0;
        bus.valid_in = 1'b0;
        bus.x_in = '0; bus.pay_in = '0; bus.cf_in = '0;

        #1 rst_n = 1'b0;
        #1;
        check("rst_valid_out", longint'(bus.valid_out), 0);
        check("rst_cf_out", longint'(bus.cf_out), 0);
        check("rst_exercise_out", longint'(bus.exercise_out), 0);
        check("rst_last_out", longint'(bus.last_out), 0);
        check("rst_ready_out", longint'(bus.ready_out), 0);
        check("rst_beta_ready_out", longint'(bus.beta_ready_out), 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // model pinned against hand-computed values
        check("model_nominal_C", cont(81920, -32768, 16384, 131072), 81920);
        check("model_sat_C", cont(0, 0, 8388607, 524288), 8388607);
        check("model_round_half_up", fmul(1, 32768), 1);

        // records offered before any beta must be ignored
        bus.x_in = 24'sd65536; bus.pay_in = 24'sd65536; bus.cf_in = 24'sd1;
        bus.valid_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ready_out_in_idle", longint'(bus.ready_out), 0);
            @(posedge clk);
            #1;
        end
        bus.valid_in = 1'b0;

        // nominal exercise and tie: beta=(1.25,-0.5,0.25), x=2.0 -> C=1.25
        send_beta(81920, -32768, 16384);
        send_rec(131072, 98304, 52429, 1'b1, 98304, 1'b1);
        send_rec(131072, 65536, 52429, 1'b1, 52429, 1'b0);
        send_rec(131072, 81920, 1000, 1'b1, 81920, 1'b1);
        send_fill(4);
        wait_idle();

        // out of the money: C=-1.0
        send_beta(-65536, 0, 0);
        send_rec(65536, 0, 19661, 1'b1, 19661, 1'b0);
        send_rec(65536, -5, 777, 1'b1, 777, 1'b0);
        send_rec(0, 1, 42, 1'b1, 1, 1'b1);
        send_fill(4);
        wait_idle();

        // saturation: b2 = max, x = 8.0 -> C clamps to max
        send_beta(0, 0, 8388607);
        send_rec(524288, 6553600, 300, 1'b1, 300, 1'b0);
        send_rec(524288, 8388606, 123, 1'b1, 123, 1'b0);
        send_rec(524288, 65536, -77, 1'b1, -77, 1'b0);
        send_fill(4);
        wait_idle();

        // full batch under backpressure, next beta offered mid-batch
        bp_en = 1'b1;
        send_beta(81920, -32768, 16384);
        bus.beta_in[0] = 24'sd40000; bus.beta_in[1] = -24'sd20000; bus.beta_in[2] = 24'sd10000;
        bus.beta_valid_in = 1'b1;
        for (int k = 1; k <= N; k++) begin
            send_rec(longint'(k) * 65536, longint'(k) * 30000 - 100000, longint'(k) * 1000, 1'b0, 0, 1'b0);
        end
        send_beta(40000, -20000, 10000);
        bp_en = 1'b0;

        // reset after five accepts
        for (int k = 1; k <= 5; k++) begin
            send_rec(longint'(k) * 65536, 200000, longint'(k), 1'b0, 0, 1'b0);
        end
        rst_n = 1'b0;
        #1;
        check("midrst_valid_out", longint'(bus.valid_out), 0);
        check("midrst_cf_out", longint'(bus.cf_out), 0);
        check("midrst_exercise_out", longint'(bus.exercise_out), 0);
        check("midrst_last_out", longint'(bus.last_out), 0);
        check("midrst_ready_out", longint'(bus.ready_out), 0);
        check("midrst_beta_ready_out", longint'(bus.beta_ready_out), 1);
`ifdef LSM_CONT_EVAL_STATS_EN
        check("midrst_ex_count", longint'(ex_count), 0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // fresh batch, ready_in held high, back-to-back: latency and throughput
        lat_mode = 1'b1;
        send_beta(32768, 16384, -8192);
        for (int k = 1; k <= N; k++) begin
            send_rec(longint'(k) * 8192, longint'(k) * 4000, longint'(k) * 3000 - 20000, 1'b0, 0, 1'b0);
        end
        wait_idle();
        lat_mode = 1'b0;
        check("first_result_latency", lat_val - lat_acc, 4);
        check("results_one_per_cycle", lat_last_fire - lat_val, N - 1);
        check("batch_result_count", lat_fires, N);
        check("scoreboard_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/lsm_continuation_eval.md
# lsm_continuation_eval

- Sits directly downstream of the regression `accumulator` in the LSM backward-induction loop.
- Latches a β triple (β0, β1, β2) once per exercise date.
- For each of N_SAMPLES path records, computes the continuation value C = β0 + β1·x + β2·x² in signed fixed point and compares it with the immediate payoff.
- Emits the path's updated cash flow and the exercise decision to the next backward step.

## Interface
- WIDTH, fpga_cfg_pkg::FP_WIDTH, total fixed-point width (two's complement)
- QINT, fpga_cfg_pkg::FP_QINT, integer bits
- QFRAC, fpga_cfg_pkg::FP_QFRAC, fractional bits
- N_SAMPLES, 16, path records per β batch (≥1)

Ports:
- clk  in  1  clock; one clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- beta_valid_in  in  1  β triple valid
- beta_ready_out  out  1  β triple accepted when both are high
- beta_in[0:2]  in  WIDTH signed  β0, β1, β2
- valid_in  in  1  path record valid
- ready_out  out  1  path record accepted when both are high
- x_in  in  WIDTH signed  regression state (underlying price)
- pay_in  in  WIDTH signed  immediate exercise payoff
- cf_in  in  WIDTH signed  discounted future cash flow
- valid_out  out  1  result valid
- ready_in  in  1  downstream ready
- cf_out  out  WIDTH signed  updated cash flow
- exercise_out  out  1  1 = exercise at this date
- last_out  out  1  marks the N_SAMPLES-th result of a batch

## Operation
- **FSM states**
  - IDLE: beta_ready_out=1; on the β handshake, latch beta_in[0:2], clear counters, go to RUN.
  - RUN: accept records; when the N_SAMPLES-th record is accepted, go to DRAIN.
  - DRAIN: ready_out=0; when the result with last_out=1 is accepted, go to IDLE.
- beta_ready_out=0 outside IDLE. The latched β is constant for the whole batch.
- **Arithmetic, all in Q(QINT.QFRAC)**
  - mul(a,b): full 2·WIDTH-bit product, add 2^(QFRAC-1), arithmetic shift right by QFRAC, saturate to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - add(a,b): WIDTH+1-bit sum, saturated to WIDTH.
  - Stage 1: x2 = mul(x,x); t1 = mul(β1,x).
  - Stage 2: t2 = mul(β2,x2); s = add(β0,t1).
  - Stage 3: C = add(s,t2).
- **Decision**
  - exercise = (pay > 0) && (pay ≥ C), signed compare.
  - cf_out = exercise ? pay : cf. pay and cf travel with the record through the pipeline.
- **Counters**
  - in_cnt counts accepted records.
  - out_cnt counts accepted results.
  - last_out = (out_cnt == N_SAMPLES−1) while valid_out.

## Timing
- Reset values:
  - state=IDLE
  - beta_ready_out=1 (combinational from state)
  - ready_out=0, valid_out=0, cf_out=0, exercise_out=0, last_out=0
  - latched β=0, counters=0
  - all pipeline valids=0
- Latency: record accepted at edge k → valid_out high after edge k+3 when ready_in is held high.
- Throughput: 1 record/cycle.
- Stall: pipeline advance enable en = !valid_out || ready_in.
  - All three stages freeze together when en=0.
  - ready_out = (state==RUN) && en.
- Output hold: while valid_out && !ready_in, cf_out, exercise_out and last_out are held stable.
- valid_in is ignored in IDLE and DRAIN. A record is never accepted before β is latched.
- beta_valid_in is ignored in RUN and DRAIN. A pending β stays unaccepted until IDLE; no overwrite mid-batch.
- Same cycle as the DRAIN→IDLE transition: beta_ready_out is still 0 that cycle. The earliest new β accept is the following cycle.
- N_SAMPLES=1: RUN→DRAIN on the first accept; that result carries last_out=1.
- Reset mid-batch: in-flight records are discarded, valid_out drops immediately, and the block returns to IDLE.

## Configuration
- LSM_CONT_EVAL_STATS_EN
  - Defined: adds output port ex_count_out [$clog2(N_SAMPLES+1)-1:0].
    - Counts results accepted with exercise_out=1 in the current batch.
    - Holds its value after the batch ends; clears to 0 on β accept and on reset.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- **Nominal exercise:** β=(1.25,−0.5,0.25), x=2.0 → C=1.25.
  - pay=1.5, cf=0.8 → exercise_out=1, cf_out=1.5.
  - pay=1.0, cf=0.8 → exercise_out=0, cf_out=0.8.
  - Both results within 1 LSB.
- **OTM and tie:**
  - pay=0, cf=0.3, C=−1.0 → no exercise, cf_out=0.3.
  - pay=C=1.25 → exercise_out=1.
- **Saturation:** β2 = max positive, x=8.0 → C clamps to 2^(WIDTH-1)−1 with no wrap, so exercise_out=0 for any pay.
- **Full batch under backpressure:** 16 records with x=k (k=1..16), ready_in randomly low ~25% of cycles.
  - Outputs are in order and match the reference model.
  - Outputs hold while stalled; last_out=1 only on the 16th.
  - A β offered during RUN is not accepted until after the 16th result.
- **Latency/throughput:** with ready_in=1 and back-to-back valid_in, the first valid_out appears 3 cycles after the first accept, then one result per cycle.
- **Reset mid-batch:** assert rst_n=0 after 5 accepts.
  - All outputs return to their reset values.
  - The next batch after a new β produces correct results and last_out on its N-th result.
  - With LSM_CONT_EVAL_STATS_EN, ex_count_out=0 after reset.
